// File: rtl/debug_controller.sv
// debug_controller: turns single-byte UART commands into processor clock-enable
// control, and serializes a snapshot of the processor debug vector, least
// significant byte first, to the UART transmitter.
//
// Handshake with the transmitter: tx_start is held high for START_HOLD cycles
// while tx_data is stable. A rising edge on tx_done completes the current byte.
// That edge may arrive during the hold or after it. tx_data does not change
// until the byte completes. rx_done and tx_done count only on their rising
// edges, so a flag held high for several cycles is a single event.
module debug_controller #(
    parameter int unsigned DBG_W      = 322,
    parameter int unsigned START_HOLD = 16,
    parameter logic [7:0]  CMD_RUN    = 8'h63,
    parameter logic [7:0]  CMD_HALT   = 8'h68,
    parameter logic [7:0]  CMD_STEP   = 8'h73,
    parameter logic [7:0]  CMD_DUMP   = 8'h64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    input  logic             tx_done,
    input  logic [DBG_W-1:0] debug_signal,
    input  logic             halt_req,
    output logic             enable,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    output logic             busy
);
    localparam int unsigned NBYTES = (DBG_W + 7) / 8;
    localparam int unsigned SNAP_W = NBYTES * 8;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned CNT_W  = $clog2(START_HOLD + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(START_HOLD - 1);

    typedef enum logic [2:0] {
        S_HALTED = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_SNAP   = 3'd3,
        S_SEND   = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_seen_q, done_seen_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic                rx_prev_q, tx_prev_q;
    logic                rx_ev, tx_ev, last_byte;

    assign rx_ev     = rx_done & ~rx_prev_q;
    assign tx_ev     = tx_done & ~tx_prev_q;
    assign last_byte = (idx_q == LAST_IDX);

    // State, byte index, hold counter, snapshot and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HALTED;
            idx_q       <= '0;
            cnt_q       <= '0;
            done_seen_q <= 1'b0;
            snap_q      <= '0;
            rx_prev_q   <= 1'b0;
            tx_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            done_seen_q <= done_seen_d;
            snap_q      <= snap_d;
            rx_prev_q   <= rx_done;
            tx_prev_q   <= tx_done;
        end
    end

    // Next-state: command decode, step/halt handling and the byte-send sequence
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        done_seen_d = done_seen_q;
        snap_d      = snap_q;
        case (state_q)
            S_HALTED: begin
                if (rx_ev) begin
                    if (rx_data == CMD_RUN)       state_d = S_RUN;
                    else if (rx_data == CMD_STEP) state_d = S_STEP;
                    else if (rx_data == CMD_DUMP) state_d = S_SNAP;
                end
            end
            S_RUN: begin
                // A halt command and halt_req in the same cycle give one transition.
                if (halt_req || (rx_ev && rx_data == CMD_HALT)) state_d = S_SNAP;
            end
            S_STEP: state_d = S_SNAP;
            S_SNAP: begin
                snap_d      = SNAP_W'(debug_signal);
                idx_d       = '0;
                cnt_d       = '0;
                done_seen_d = 1'b0;
                state_d     = S_SEND;
            end
            S_SEND: begin
                // A tx_done edge during the hold is remembered; the byte is
                // retired when the hold ends.
                if (tx_ev) done_seen_d = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (done_seen_q || tx_ev) begin
                        done_seen_d = 1'b0;
                        if (last_byte) begin
                            state_d = S_HALTED;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_SEND;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (tx_ev) begin
                    cnt_d = '0;
                    if (last_byte) begin
                        state_d = S_HALTED;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_HALTED;
        endcase
    end

    // Outputs are decoded from the registered state, so they are glitch-free
    // and fall to reset values as soon as rst_n is asserted.
    always_comb begin
        enable   = (state_q == S_RUN) || (state_q == S_STEP);
        tx_start = (state_q == S_SEND);
        busy     = (state_q == S_SNAP) || (state_q == S_SEND) || (state_q == S_WAIT);
        tx_data  = snap_q[{idx_q, 3'b000} +: 8];
    end

endmodule
